// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Two-requester round-robin arbiter feeding a UART transmitter. A grant
// produces a one-cycle SEND (txe plus the winner's ack), after which the
// block waits FRAME_CYCLES cycles so the UART can finish the frame before
// the next grant.
module serial_tx_arbiter #(
    parameter int FRAME_CYCLES = 62400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ack,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ack,
    output logic       txe,
    output logic [7:0] dat_t,
    output logic       busy,
    output logic       grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // The counter is loaded on leaving SEND and reaches zero on the last
    // WAIT cycle, so WAIT spans exactly FRAME_CYCLES cycles.
    localparam logic [15:0] CNT_LOAD = 16'(FRAME_CYCLES - 1);

    logic [1:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  dat_reg, dat_next;
    logic        grant_reg, grant_next;

    logic [1:0]  valid_vec;
    logic [1:0]  ack_vec;
    logic        winner;
    logic        in_send;

    assign valid_vec = {req1_valid, req0_valid};
    assign in_send   = (state_reg == SEND);

    // On a tie the requester that did not win last time goes next; the reset
    // value of grant_reg (1) lets requester 0 win the first tie.
    assign winner = (&valid_vec) ? ~grant_reg : valid_vec[1];

    // Each requester's ack is the SEND pulse qualified by the stored grant.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = in_send && (grant_reg == 1'(gi));
        end
    endgenerate

    assign req0_ack = ack_vec[0];
    assign req1_ack = ack_vec[1];
    assign txe      = in_send;
    assign dat_t    = dat_reg;
    assign busy     = (state_reg != IDLE);
    assign grant_id = grant_reg;

    // Next-state logic: grant in IDLE, single SEND cycle, counted WAIT.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dat_next   = dat_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (en && (|valid_vec)) begin
                    grant_next = winner;
                    dat_next   = winner ? req1_data : req0_data;
                    state_next = SEND;
                end
            end
            SEND: begin
                cnt_next   = CNT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    // State registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'd0;
            dat_reg   <= 8'h00;
            grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dat_reg   <= dat_next;
            grant_reg <= grant_next;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed testbench for serial_tx_arbiter with FRAME_CYCLES=20.
// Cycle n is the interval after the n-th rising edge counted from the start
// of each scenario; outputs are sampled 1 ns after the edge.
module tb_serial_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ack;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ack;
    logic       txe;
    logic [7:0] dat_t;
    logic       busy;
    logic       grant_id;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int viol = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    int       ev_cyc[$];
    logic [7:0] ev_dat[$];
    logic     ev_ack1[$];

    serial_tx_arbiter #(.FRAME_CYCLES(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ack   (req0_ack),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ack   (req1_ack),
        .txe        (txe),
        .dat_t      (dat_t),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and log any transmit transaction.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (req0_ack) ack0_cnt++;
        if (req1_ack) ack1_cnt++;
        if ((req0_ack || req1_ack) && !txe) viol++;
        if (req0_ack && req1_ack) viol++;
        if (txe && !(req0_ack ^ req1_ack)) viol++;
        if (txe) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(dat_t);
            ev_ack1.push_back(req1_ack);
            $display("[TB] txe cyc=%0d dat=%02h ack0=%0b ack1=%0b", cyc, dat_t, req0_ack, req1_ack);
        end
    endtask

    task automatic run_to(input int last);
        while (cyc < last) step();
    endtask

    // Reset for two cycles, then clear logs; the caller's next cycle is 0.
    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = 8'h00;
        req1_data = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        ev_cyc.delete();
        ev_dat.delete();
        ev_ack1.delete();
        ack0_cnt = 0;
        ack1_cnt = 0;
        cyc = 0;
    endtask

    // Compare logged grants against expected cycle/data/ack tables.
    task automatic check_events(input string tag, input int n, input int c0, input int gap,
                                input logic [7:0] d_even, input logic [7:0] d_odd,
                                input logic a_even, input logic a_odd);
        check({tag, "_count"}, ev_cyc.size(), n);
        for (int i = 0; i < n && i < ev_cyc.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), ev_cyc[i], c0 + i * gap);
            check($sformatf("%s_dat%0d", tag, i), ev_dat[i], (i % 2 == 0) ? d_even : d_odd);
            check($sformatf("%s_ack1_%0d", tag, i), ev_ack1[i], (i % 2 == 0) ? a_even : a_odd);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_txe", txe, 0);
        check("rst_ack0", req0_ack, 0);
        check("rst_ack1", req1_ack, 0);
        check("rst_dat", dat_t, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 1);

        // Single request from requester 0
        req0_valid = 1'b1;
        req0_data = 8'hA5;
        step();
        check("single_txe", txe, 1);
        check("single_ack0", req0_ack, 1);
        check("single_ack1", req1_ack, 0);
        check("single_dat", dat_t, 8'hA5);
        check("single_grant", grant_id, 0);
        req0_valid = 1'b0;
        run_to(21);
        check("single_busy21", busy, 1);
        step();
        check("single_busy22", busy, 0);
        check("single_dat_hold", dat_t, 8'hA5);
        check("single_events", ev_cyc.size(), 1);

        // Both requesters valid: alternate grants
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        run_to(70);
        check_events("rr", 4, 1, 22, 8'h11, 8'h22, 1'b0, 1'b1);

        // Only requester 1 valid
        do_reset();
        req1_valid = 1'b1; req1_data = 8'h3C;
        run_to(70);
        check_events("r1", 4, 1, 22, 8'h3C, 8'h3C, 1'b1, 1'b1);
        check("r1_no_ack0", ack0_cnt, 0);

        // en low blocks grants
        do_reset();
        en = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h5A;
        run_to(10);
        check("en_busy_off", busy, 0);
        en = 1'b1;
        run_to(15);
        check_events("en", 1, 11, 22, 8'h5A, 8'h5A, 1'b0, 1'b0);

        // Reset during WAIT with request still pending
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h77;
        run_to(10);
        check("wrst_busy_pre", busy, 1);
        rst_n = 1'b0;
        step();
        check("wrst_busy", busy, 0);
        check("wrst_dat", dat_t, 8'h00);
        check("wrst_grant", grant_id, 1);
        rst_n = 1'b1;
        run_to(14);
        req0_valid = 1'b0;
        check("wrst_ev_count", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) check("wrst_ev_cyc", ev_cyc[1], 12);

        // Valid held across ack then dropped
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hC3;
        run_to(4);
        req0_valid = 1'b0;
        run_to(40);
        check("hold_ack0", ack0_cnt, 1);
        check("hold_txe", ev_cyc.size(), 1);

        check("protocol_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
